// File: rtl/mul_share_pkg.sv
// Shared constants and enums for the two-requester shared multiplier.
package mul_share_pkg;
  localparam int WS_DEF = 16;
  localparam int WL_DEF = 32;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    DONE   = 2'd2
  } req_state_t;
endpackage

// File: rtl/mul_stage.sv
// Operand capture stage of the shared multiplier; the product is formed from
// the captured operands and loaded by the owner one edge later.
module mul_stage
  import mul_share_pkg::*;
#(
  parameter int WS = WS_DEF,
  parameter int WL = WL_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  req_id_t       i_tag,
  input  logic [WS-1:0] i_x,
  input  logic [WS-1:0] i_y,
  output logic          o_valid,
  output req_id_t       o_tag,
  output logic [WL-1:0] o_p
);

  logic          r_s1_valid;
  req_id_t       r_tag;
  logic [WS-1:0] r_na;
  logic [WS-1:0] r_nb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_tag      <= REQ_A;
      r_na       <= '0;
      r_nb       <= '0;
    end else begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_tag <= i_tag;
        r_na  <= i_x;
        r_nb  <= i_y;
      end
    end
  end

  assign o_valid = r_s1_valid;
  assign o_tag   = r_tag;
  assign o_p     = WL'(r_na) * WL'(r_nb);

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one registered multiplier between requesters A and B,
// each limited to a single outstanding operation.
//   state  | meaning
//   IDLE   | ready for new operands
//   ISSUED | operands captured in the multiplier stage
//   DONE   | product held until the requester consumes it
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int WS = WS_DEF,
  parameter int WL = WL_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [WS-1:0] a_x,
  input  logic [WS-1:0] a_y,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [WS-1:0] b_x,
  input  logic [WS-1:0] b_y,
  output logic          ra_valid,
  input  logic          ra_ready,
  output logic [WL-1:0] ra_p,
  output logic          rb_valid,
  input  logic          rb_ready,
  output logic [WL-1:0] rb_p
);

  req_state_t    r_st_a;
  req_state_t    r_st_b;
  req_id_t       r_rr_pri;   // requester that wins a tie (the one not granted last)
  logic [WL-1:0] r_ra_p;
  logic [WL-1:0] r_rb_p;

  logic          w_elig_a;
  logic          w_elig_b;
  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          w_s1_valid;
  req_id_t       w_s1_tag;
  logic [WL-1:0] w_prod;
  logic          w_res_a;
  logic          w_res_b;

  assign a_ready  = (r_st_a == IDLE);
  assign b_ready  = (r_st_b == IDLE);
  assign ra_valid = (r_st_a == DONE);
  assign rb_valid = (r_st_b == DONE);
  assign ra_p     = r_ra_p;
  assign rb_p     = r_rb_p;

  assign w_elig_a = a_valid && a_ready;
  assign w_elig_b = b_valid && b_ready;
  assign w_gnt_a  = w_elig_a && (!w_elig_b || (r_rr_pri == REQ_A));
  assign w_gnt_b  = w_elig_b && !w_gnt_a;

  assign w_res_a  = w_s1_valid && (w_s1_tag == REQ_A);
  assign w_res_b  = w_s1_valid && (w_s1_tag == REQ_B);

  mul_stage #(.WS(WS), .WL(WL)) u_mul_stage (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_gnt_a || w_gnt_b),
    .i_tag   (w_gnt_b ? REQ_B : REQ_A),
    .i_x     (w_gnt_b ? b_x : a_x),
    .i_y     (w_gnt_b ? b_y : a_y),
    .o_valid (w_s1_valid),
    .o_tag   (w_s1_tag),
    .o_p     (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_a   <= IDLE;
      r_st_b   <= IDLE;
      r_rr_pri <= REQ_A;
      r_ra_p   <= '0;
      r_rb_p   <= '0;
    end else begin
      if (w_gnt_a)      r_rr_pri <= REQ_B;
      else if (w_gnt_b) r_rr_pri <= REQ_A;

      case (r_st_a)
        IDLE:    if (w_gnt_a)  r_st_a <= ISSUED;
        ISSUED:  if (w_res_a)  r_st_a <= DONE;
        DONE:    if (ra_ready) r_st_a <= IDLE;
        default:               r_st_a <= IDLE;
      endcase

      case (r_st_b)
        IDLE:    if (w_gnt_b)  r_st_b <= ISSUED;
        ISSUED:  if (w_res_b)  r_st_b <= DONE;
        DONE:    if (rb_ready) r_st_b <= IDLE;
        default:               r_st_b <= IDLE;
      endcase

      if (w_res_a) r_ra_p <= w_prod;
      if (w_res_b) r_rb_p <= w_prod;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed and random checks of the shared multiplier arbiter.
module tb_mul_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, ra_ready, rb_ready;
  logic        a_ready, b_ready, ra_valid, rb_valid;
  logic [15:0] a_x, a_y, b_x, b_y;
  logic [31:0] ra_p, rb_p;

  int total = 0;
  int bad   = 0;

  mul_share_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_x      (a_x),
    .a_y      (a_y),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_x      (b_x),
    .b_y      (b_y),
    .ra_valid (ra_valid),
    .ra_ready (ra_ready),
    .ra_p     (ra_p),
    .rb_valid (rb_valid),
    .rb_ready (rb_ready),
    .rb_p     (rb_p)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_ready"}, a_ready, 1);
    check({tag, "_b_ready"}, b_ready, 1);
    check({tag, "_ra_valid"}, ra_valid, 0);
    check({tag, "_rb_valid"}, rb_valid, 0);
    check({tag, "_ra_p"}, ra_p, 0);
    check({tag, "_rb_p"}, rb_p, 0);
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  initial begin
    int  cnt, ng;
    logic pa, pb, ga, gb, last_a, gen, acc_a, acc_b;

    rst = 1'b1;
    a_valid = 0; b_valid = 0; ra_ready = 0; rb_ready = 0;
    a_x = 0; a_y = 0; b_x = 0; b_y = 0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_reset_outputs("reset");

    // single A issue 3*5
    a_valid = 1; a_x = 3; a_y = 5;
    step();
    a_valid = 0;
    check("t1_a_ready_low", a_ready, 0);
    check("t1_ra_valid_early", ra_valid, 0);
    step();
    check("t1_ra_valid", ra_valid, 1);
    check("t1_ra_p", ra_p, 15);
    repeat (2) step();
    check("t1_ra_hold_valid", ra_valid, 1);
    check("t1_ra_hold_p", ra_p, 15);
    check("t1_a_ready_hold", a_ready, 0);
    ra_ready = 1;
    step();
    ra_ready = 0;
    check("t1_ra_consumed", ra_valid, 0);
    check("t1_a_ready_back", a_ready, 1);

    // tie after an A grant: B wins
    a_valid = 1; a_x = 6; a_y = 7;
    b_valid = 1; b_x = 5; b_y = 5;
    step();
    b_valid = 0;
    check("tieb_b_granted", b_ready, 0);
    check("tieb_a_waiting", a_ready, 1);
    step();
    a_valid = 0;
    check("tieb_a_granted", a_ready, 0);
    check("tieb_rb_valid", rb_valid, 1);
    check("tieb_rb_p", rb_p, 25);
    step();
    check("tieb_ra_valid", ra_valid, 1);
    check("tieb_ra_p", ra_p, 42);
    ra_ready = 1; rb_ready = 1;
    step();
    ra_ready = 0; rb_ready = 0;

    // solo B issue 2*3 so that B was last granted
    b_valid = 1; b_x = 2; b_y = 3;
    step();
    b_valid = 0;
    check("solob_b_ready", b_ready, 0);
    step();
    check("solob_rb_valid", rb_valid, 1);
    check("solob_rb_p", rb_p, 6);
    rb_ready = 1;
    step();
    rb_ready = 0;
    check("solob_b_ready_back", b_ready, 1);

    // tie after a B grant: A 7*9 first, then B 0xFFFF*0xFFFF
    a_valid = 1; a_x = 7; a_y = 9;
    b_valid = 1; b_x = 16'hFFFF; b_y = 16'hFFFF;
    step();
    a_valid = 0;
    check("t2_a_granted", a_ready, 0);
    check("t2_b_waiting", b_ready, 1);
    step();
    b_valid = 0;
    check("t2_ra_valid", ra_valid, 1);
    check("t2_ra_p", ra_p, 63);
    check("t2_rb_valid_early", rb_valid, 0);
    check("t2_b_granted", b_ready, 0);
    step();
    check("t2_rb_valid", rb_valid, 1);
    check("t2_rb_p", rb_p, 32'hFFFE0001);
    ra_ready = 1; rb_ready = 1;
    step();
    ra_ready = 0; rb_ready = 0;
    check("t2_ra_consumed", ra_valid, 0);
    check("t2_rb_consumed", rb_valid, 0);

    // backpressure on A while B issues three times
    a_valid = 1; a_x = 10; a_y = 11;
    step();
    b_valid = 1; b_x = 2; b_y = 2; rb_ready = 1;
    step();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_a_ready", a_ready, 0);
      check("t3_ra_valid", ra_valid, 1);
      check("t3_ra_p", ra_p, 110);
      if (rb_valid) begin
        check("t3_rb_p", rb_p, 4);
        cnt++;
        if (cnt == 3) b_valid = 0;
      end
    end
    check("t3_b_count", cnt, 3);
    a_valid = 0; ra_ready = 1; rb_ready = 0;
    step();
    ra_ready = 0;
    check("t3_ra_consumed", ra_valid, 0);
    check("t3_a_ready_back", a_ready, 1);
    check("t3_b_ready", b_ready, 1);

    // fairness with continuous requests and immediate consume
    a_valid = 1; a_x = 100; a_y = 200;
    b_valid = 1; b_x = 300; b_y = 400;
    ra_ready = 1; rb_ready = 1;
    ng = 0; last_a = 0;
    for (int i = 0; i < 12; i++) begin
      pa = a_valid && a_ready;
      pb = b_valid && b_ready;
      step();
      ga = pa && !a_ready;
      gb = pb && !b_ready;
      check("t4_one_grant", ga && gb, 0);
      if (ga || gb) begin
        if (ng == 0) check("t4_first_a", ga, 1);
        else         check("t4_alternate", ga, !last_a);
        last_a = ga;
        ng++;
      end
      if (ra_valid) check("t4_ra_p", ra_p, 20000);
      if (rb_valid) check("t4_rb_p", rb_p, 120000);
    end
    check("t4_grant_count", ng, 8);
    a_valid = 0; b_valid = 0;
    repeat (3) step();
    check("t4_drain_ra", ra_valid, 0);
    check("t4_drain_rb", rb_valid, 0);
    ra_ready = 0; rb_ready = 0;

    // reset the cycle after A's grant of 4*4
    a_valid = 1; a_x = 4; a_y = 4;
    step();
    a_valid = 0; rst = 1;
    b_valid = 1; b_x = 9; b_y = 9;
    step();
    rst = 0; b_valid = 0;
    check_reset_outputs("t5");
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_ra", ra_valid, 0);
      check("t5_no_rb", rb_valid, 0);
      check("t5_b_ready", b_ready, 1);
    end
    a_valid = 1; a_x = 0; a_y = 123;
    step();
    a_valid = 0;
    step();
    check("t5_zero_valid", ra_valid, 1);
    check("t5_zero_p", ra_p, 0);
    ra_ready = 1;
    step();
    ra_ready = 0;

    // random issue/consume against a per-requester queue model
    for (int i = 0; i < 10200; i++) begin
      gen = (i < 10000);
      ra_ready = gen ? 1'($urandom_range(0, 1)) : 1'b1;
      rb_ready = gen ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ra_valid && ra_ready) begin
        check("rnd_a_expected", qa.size() != 0, 1);
        if (qa.size() != 0) check("rnd_a_p", ra_p, qa.pop_front());
      end
      if (rb_valid && rb_ready) begin
        check("rnd_b_expected", qb.size() != 0, 1);
        if (qb.size() != 0) check("rnd_b_p", rb_p, qb.pop_front());
      end
      pa = a_valid && a_ready;
      pb = b_valid && b_ready;
      step();
      acc_a = pa && !a_ready;
      acc_b = pb && !b_ready;
      check("rnd_one_grant", acc_a && acc_b, 0);
      if (acc_a) qa.push_back({16'h0, a_x} * {16'h0, a_y});
      if (acc_b) qb.push_back({16'h0, b_x} * {16'h0, b_y});
      if (!a_valid || acc_a) begin
        a_valid = gen && ($urandom_range(0, 3) != 0);
        a_x = rnd_op(); a_y = rnd_op();
      end
      if (!b_valid || acc_b) begin
        b_valid = gen && ($urandom_range(0, 3) != 0);
        b_x = rnd_op(); b_y = rnd_op();
      end
    end
    check("rnd_a_drained", qa.size(), 0);
    check("rnd_b_drained", qb.size(), 0);
    check("rnd_a_idle", a_ready, 1);
    check("rnd_b_idle", b_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
